// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, frame constants and baud divider.
// Used by both the transmit and receive paths.
package uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } uart_state_e;

   localparam int DATA_BITS = 8;
   localparam int STOP_BITS = 1;

   function automatic int calc_div(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with level and full/empty flags.
// Pointers carry one extra MSB so full and empty are distinguishable.
module uart_tx_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic [$clog2(DEPTH):0]   level_o,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wptr_q, wptr_d;
   logic [AW:0]      rptr_q, rptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             push_en, pop_en;

   assign level_o = wptr_q - rptr_q;
   assign full_o  = (level_o == (AW+1)'(DEPTH));
   assign empty_o = (level_o == '0);
   assign rdata_o = mem_q[rptr_q[AW-1:0]];

   assign push_en = push_i && !full_o;
   assign pop_en  = pop_i && !empty_o;

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (push_en) wptr_d = wptr_q + 1'b1;
      if (pop_en)  rptr_d = rptr_q + 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_en) mem_q[wptr_q[AW-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with input FIFO for the FTDI host link.
// Back-to-back frames start on the same edge that ends the stop bit.
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLK_HZ     = 25000000,
   parameter int BAUD       = 115200,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                        clk_25mhz,
   input  logic                        rst_n,
   input  logic [7:0]                  tx_data,
   input  logic                        tx_valid,
   output logic                        tx_ready,
   output logic                        ftdi_rxd,
   output logic                        busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

   localparam int DIV  = calc_div(CLK_HZ, BAUD);
   localparam int BW   = (DIV < 2) ? 1 : $clog2(DIV);
   localparam int BITW = $clog2(DATA_BITS);

   if (DIV < 2) begin : g_div_chk
      $error("uart_tx: CLK_HZ/BAUD must be at least 2");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_fifo_chk
      $error("uart_tx: FIFO_DEPTH must be a power of two >= 2");
   end

   uart_state_e     state_q, state_d;
   logic [BW-1:0]   baud_q, baud_d;
   logic [BITW-1:0] bit_q, bit_d;
   logic [7:0]      shift_q, shift_d;
   logic            line_q, line_d;
   logic            pop;
   logic            tick;
   logic            fifo_full, fifo_empty;
   logic [7:0]      fifo_rdata;

   uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk_i   (clk_25mhz),
      .rst_ni  (rst_n),
      .push_i  (tx_valid),
      .wdata_i (tx_data),
      .pop_i   (pop),
      .rdata_o (fifo_rdata),
      .level_o (fifo_level),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign tx_ready = !fifo_full;
   assign ftdi_rxd = line_q;
   assign busy     = (state_q != ST_IDLE) || !fifo_empty;
   assign tick     = (baud_q == BW'(DIV - 1));

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      line_d  = line_q;
      pop     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               shift_d = fifo_rdata;
               line_d  = 1'b0;
               baud_d  = '0;
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (tick) begin
               baud_d  = '0;
               bit_d   = '0;
               line_d  = shift_q[0];
               state_d = ST_DATA;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         ST_DATA: begin
            if (tick) begin
               baud_d = '0;
               if (bit_q == BITW'(DATA_BITS - 1)) begin
                  line_d  = 1'b1;
                  state_d = ST_STOP;
               end else begin
                  shift_d = shift_q >> 1;
                  line_d  = shift_q[1];
                  bit_d   = bit_q + 1'b1;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         ST_STOP: begin
            if (tick) begin
               baud_d = '0;
               // chain the next start bit directly, no idle gap
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  shift_d = fifo_rdata;
                  line_d  = 1'b0;
                  state_d = ST_START;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_25mhz or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         line_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         line_q  <= line_d;
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: DIV=4 (depth 8 and 4) and default rates.
// Serial output is decoded by sampling at mid-bit.
module tb_uart_tx;

   logic       clk;
   logic       rst_n;
   int         checks;
   int         errors;
   int         cyc;

   logic [7:0] data_a, data_b, data_c;
   logic       valid_a, valid_b, valid_c;
   logic       ready_a, ready_b, ready_c;
   logic       rxd_a, rxd_b, rxd_c;
   logic       busy_a, busy_b, busy_c;
   logic [3:0] lvl_a;
   logic [2:0] lvl_b;
   logic [3:0] lvl_c;

   logic [7:0] burst [4];
   logic [7:0] six   [6];

   uart_tx #(.CLK_HZ(25000000), .BAUD(6250000), .FIFO_DEPTH(8)) u_a (
      .clk_25mhz (clk),
      .rst_n     (rst_n),
      .tx_data   (data_a),
      .tx_valid  (valid_a),
      .tx_ready  (ready_a),
      .ftdi_rxd  (rxd_a),
      .busy      (busy_a),
      .fifo_level(lvl_a)
   );

   uart_tx #(.CLK_HZ(25000000), .BAUD(6250000), .FIFO_DEPTH(4)) u_b (
      .clk_25mhz (clk),
      .rst_n     (rst_n),
      .tx_data   (data_b),
      .tx_valid  (valid_b),
      .tx_ready  (ready_b),
      .ftdi_rxd  (rxd_b),
      .busy      (busy_b),
      .fifo_level(lvl_b)
   );

   uart_tx u_c (
      .clk_25mhz (clk),
      .rst_n     (rst_n),
      .tx_data   (data_c),
      .tx_valid  (valid_c),
      .tx_ready  (ready_c),
      .ftdi_rxd  (rxd_c),
      .busy      (busy_c),
      .fifo_level(lvl_c)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic line_of(input int s);
      case (s)
         0:       return rxd_a;
         1:       return rxd_b;
         default: return rxd_c;
      endcase
   endfunction

   task automatic recv(input int s, input int div,
                       output logic [7:0] b, output int t0);
      int n;
      b  = '0;
      t0 = -1;
      n  = 0;
      while (line_of(s) !== 1'b0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("rx_start_seen", 32'(n < 3000), 32'd1);
      if (n >= 3000) return;
      t0 = cyc;
      repeat (div / 2) @(negedge clk);
      check("rx_start_bit", 32'(line_of(s)), 32'd0);
      for (int k = 0; k < 8; k++) begin
         repeat (div) @(negedge clk);
         b[k] = line_of(s);
      end
      repeat (div) @(negedge clk);
      check("rx_stop_bit", 32'(line_of(s)), 32'd1);
   endtask

   initial begin
      logic [9:0] fr;
      logic [7:0] dec;
      int         errs;
      int         lows;
      int         lvl_bad;

      checks  = 0;
      errors  = 0;
      rst_n   = 1'b0;
      data_a  = '0;
      data_b  = '0;
      data_c  = '0;
      valid_a = 1'b0;
      valid_b = 1'b0;
      valid_c = 1'b0;
      burst   = '{8'hA3, 8'h00, 8'hFF, 8'h81};
      six     = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};

      // reset
      repeat (3) @(negedge clk);
      check("rst_rxd", 32'(rxd_a), 32'd1);
      check("rst_ready", 32'(ready_a), 32'd1);
      check("rst_busy", 32'(busy_a), 32'd0);
      check("rst_level", 32'(lvl_a), 32'd0);
      check("rst_level_b", 32'(lvl_b), 32'd0);
      rst_n = 1'b1;
      lows = 0;
      repeat (50) begin
         @(negedge clk);
         if (rxd_a !== 1'b1) lows++;
      end
      check("idle_line_high", 32'(lows), 32'd0);

      // single byte 0x55 with exact bit timing
      data_a  = 8'h55;
      valid_a = 1'b1;
      @(negedge clk);
      valid_a = 1'b0;
      check("single_level_1", 32'(lvl_a), 32'd1);
      check("single_line_before", 32'(rxd_a), 32'd1);
      fr   = {1'b1, 8'h55, 1'b0};
      errs = 0;
      dec  = '0;
      for (int j = 0; j < 40; j++) begin
         @(negedge clk);
         if (rxd_a !== fr[j/4]) errs++;
         if ((j % 4) == 2 && j >= 4 && j < 36) dec[j/4-1] = rxd_a;
         if (j == 0) begin
            check("single_level_0", 32'(lvl_a), 32'd0);
            check("single_busy_1", 32'(busy_a), 32'd1);
         end
      end
      check("single_bit_errs", 32'(errs), 32'd0);
      check("single_decode", 32'(dec), 32'h55);
      check("single_busy_n40", 32'(busy_a), 32'd1);
      @(negedge clk);
      check("single_busy_n41", 32'(busy_a), 32'd0);
      check("single_line_idle", 32'(rxd_a), 32'd1);
      repeat (5) @(negedge clk);

      // burst of four back-to-back frames
      fork
         begin
            for (int i = 0; i < 4; i++) begin
               data_a  = burst[i];
               valid_a = 1'b1;
               @(negedge clk);
            end
            valid_a = 1'b0;
         end
         begin
            logic [7:0] b;
            int         t, tp;
            tp = 0;
            for (int i = 0; i < 4; i++) begin
               recv(0, 4, b, t);
               check("burst_byte", 32'(b), 32'(burst[i]));
               if (i > 0) check("burst_spacing", 32'(t - tp), 32'd40);
               tp = t;
            end
         end
      join
      repeat (4) @(negedge clk);
      check("burst_busy_done", 32'(busy_a), 32'd0);
      check("burst_level_done", 32'(lvl_a), 32'd0);

      // full FIFO with depth 4 and continuous valid
      fork
         begin
            int  n;
            int  stall;
            bit  seen;
            stall = 0;
            seen  = 1'b0;
            for (int i = 0; i < 6; i++) begin
               data_b  = six[i];
               valid_b = 1'b1;
               n = 0;
               while (!ready_b && n < 500) begin
                  if (!seen) begin
                     check("full_level", 32'(lvl_b), 32'd4);
                     seen = 1'b1;
                  end
                  stall++;
                  @(negedge clk);
                  n++;
               end
               @(negedge clk);
            end
            valid_b = 1'b0;
            check("full_stalled", 32'(stall > 0), 32'd1);
         end
         begin
            logic [7:0] b;
            int         t;
            for (int i = 0; i < 6; i++) begin
               recv(1, 4, b, t);
               check("full_byte", 32'(b), 32'(six[i]));
            end
         end
      join
      repeat (4) @(negedge clk);
      check("full_busy_done", 32'(busy_b), 32'd0);

      // reset during data bit 3 of 0xC6 with two bytes queued
      data_a  = 8'hC6;
      valid_a = 1'b1;
      @(negedge clk);
      data_a = 8'h11;
      @(negedge clk);
      data_a = 8'h22;
      @(negedge clk);
      valid_a = 1'b0;
      repeat (16) @(negedge clk);
      check("midrst_bit3_low", 32'(rxd_a), 32'd0);
      check("midrst_queued", 32'(lvl_a), 32'd2);
      rst_n = 1'b0;
      #1;
      check("midrst_line_high", 32'(rxd_a), 32'd1);
      check("midrst_level_0", 32'(lvl_a), 32'd0);
      @(negedge clk);
      rst_n   = 1'b1;
      lows    = 0;
      lvl_bad = 0;
      repeat (100) begin
         @(negedge clk);
         if (rxd_a !== 1'b1) lows++;
         if (lvl_a !== 4'd0) lvl_bad++;
      end
      check("midrst_no_frames", 32'(lows), 32'd0);
      check("midrst_level_stays_0", 32'(lvl_bad), 32'd0);
      check("midrst_busy", 32'(busy_a), 32'd0);

      // default rate, DIV=217
      data_c  = 8'h41;
      valid_c = 1'b1;
      @(negedge clk);
      valid_c = 1'b0;
      check("dflt_level_1", 32'(lvl_c), 32'd1);
      fr   = {1'b1, 8'h41, 1'b0};
      errs = 0;
      dec  = '0;
      for (int j = 0; j < 2170; j++) begin
         @(negedge clk);
         if (rxd_c !== fr[j/217]) errs++;
         if ((j % 217) == 108 && j >= 217 && j < 9 * 217) dec[j/217-1] = rxd_c;
      end
      check("dflt_bit_errs", 32'(errs), 32'd0);
      check("dflt_decode", 32'(dec), 32'h41);
      check("dflt_busy_end", 32'(busy_c), 32'd1);
      @(negedge clk);
      check("dflt_busy_fall", 32'(busy_c), 32'd0);
      check("dflt_line_idle", 32'(rxd_c), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
